// File: rtl/dot_round_ctrl_if.sv
// Signal bundle between the game FSM / renderer and the dot round sequencer.
// The slave side is the sequencer; the master side drives frame control and player position.
interface dot_round_ctrl_if #(
    parameter int NUM_DOTS = 8
);
    logic                      soft_reset;
    logic                      frame_tick;
    logic [9:0]                player_x;
    logic [9:0]                player_y;
    logic [NUM_DOTS-1:0]       alive_mask;
    logic [10*NUM_DOTS-1:0]    dot_x_flat;
    logic [10*NUM_DOTS-1:0]    dot_y_flat;
    logic [7:0]                score;
    logic                      eat_pulse;
    logic                      level_clear;
    logic                      frame_overrun;
    logic                      busy;

    modport master (
        output soft_reset, frame_tick, player_x, player_y,
        input  alive_mask, dot_x_flat, dot_y_flat, score,
        input  eat_pulse, level_clear, frame_overrun, busy
    );

    modport slave (
        input  soft_reset, frame_tick, player_x, player_y,
        output alive_mask, dot_x_flat, dot_y_flat, score,
        output eat_pulse, level_clear, frame_overrun, busy
    );
endinterface

// File: rtl/dot_round_ctrl.sv
// Dot-field sequencer: LFSR-seeded spawn, one-dot-at-a-time collision scan per frame
// through a single squared-distance unit, score keeping and level-clear signalling.
module dot_round_ctrl #(
    parameter int NUM_DOTS   = 8,
    parameter int SIZE       = 16,
    parameter int DOT_RADIUS = 6,
    parameter int X_SPAN     = 600,
    parameter int Y_SPAN     = 400,
    parameter int MARGIN     = 20
) (
    input  logic             clk,
    input  logic             rst,
    dot_round_ctrl_if.slave  bus
);
    localparam int               IDX_W    = (NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOTS - 1);
    localparam int               HIT_R    = DOT_RADIUS + SIZE / 2 + 2;
    localparam logic [21:0]      HIT_R2   = 22'(HIT_R * HIT_R);
    localparam logic [10:0]      HALF     = 11'(SIZE / 2);
    localparam logic [16:0]      X_SPAN_V = 17'(X_SPAN);
    localparam logic [16:0]      Y_SPAN_V = 17'(Y_SPAN);
    localparam logic [16:0]      MARGIN_V = 17'(MARGIN);

    typedef enum logic [2:0] {
        S_SEED  = 3'd0,
        S_SPAWN = 3'd1,
        S_PLAY  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [15:0]                 r_lfsr;
    logic [15:0]                 r_cnt;
    logic [15:0]                 r_base;
    logic [IDX_W-1:0]            r_idx;
    logic                        r_phase;
    logic [10:0]                 r_pcx;
    logic [10:0]                 r_pcy;
    logic [10:0]                 r_dx;
    logic [10:0]                 r_dy;
    logic [NUM_DOTS-1:0][9:0]    r_x;
    logic [NUM_DOTS-1:0][9:0]    r_y;
    logic [NUM_DOTS-1:0]         r_alive;
    logic                        r_ate;
    logic [7:0]                  r_score;
    logic                        r_eat;
    logic                        r_level_clear;
    logic                        r_overrun;
    logic                        r_busy;

    logic [15:0] w_lfsr_shift;
    logic [16:0] w_sum_x;
    logic [16:0] w_sum_y;
    logic [9:0]  w_spawn_x;
    logic [9:0]  w_spawn_y;
    logic [10:0] w_cx;
    logic [10:0] w_cy;
    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic [21:0] w_d2;
    logic        w_hit;
    logic        w_last;
    logic        w_latch_base;
    logic        w_spawn_we;
    logic        w_latch_player;
    logic        w_eat;
    logic        w_level_clear;
    logic        w_overrun;

    assign w_lfsr_shift = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    assign w_sum_x   = {1'b0, r_base} + 17'(r_idx) * 17'd53;
    assign w_sum_y   = {1'b0, r_base} + 17'(r_idx) * 17'd91;
    assign w_spawn_x = 10'((w_sum_x % X_SPAN_V) + MARGIN_V);
    assign w_spawn_y = 10'((w_sum_y % Y_SPAN_V) + MARGIN_V);

    // Phase A operands: absolute centre-to-dot distance per axis.
    assign w_cx = {1'b0, r_x[r_idx]};
    assign w_cy = {1'b0, r_y[r_idx]};
    assign w_dx = (r_pcx >= w_cx) ? (r_pcx - w_cx) : (w_cx - r_pcx);
    assign w_dy = (r_pcy >= w_cy) ? (r_pcy - w_cy) : (w_cy - r_pcy);

    assign w_d2   = 22'(r_dx) * 22'(r_dx) + 22'(r_dy) * 22'(r_dy);
    assign w_hit  = r_alive[r_idx] && (w_d2 <= HIT_R2);
    assign w_last = (r_idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_SEED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle control strobes; soft_reset overrides everything.
    always_comb begin
        w_state_next   = r_state;
        w_latch_base   = 1'b0;
        w_spawn_we     = 1'b0;
        w_latch_player = 1'b0;
        w_eat          = 1'b0;
        w_level_clear  = 1'b0;
        w_overrun      = 1'b0;
        if (bus.soft_reset) begin
            w_state_next = S_SEED;
        end else begin
            case (r_state)
                S_SEED: begin
                    if (bus.frame_tick) begin
                        w_latch_base = 1'b1;
                        w_state_next = S_SPAWN;
                    end else begin
                        w_state_next = S_SEED;
                    end
                end
                S_SPAWN: begin
                    w_spawn_we   = 1'b1;
                    w_overrun    = bus.frame_tick;
                    w_state_next = w_last ? S_PLAY : S_SPAWN;
                end
                S_PLAY: begin
                    if (bus.frame_tick) begin
                        w_latch_player = 1'b1;
                        w_state_next   = S_CHECK;
                    end else begin
                        w_state_next = S_PLAY;
                    end
                end
                S_CHECK: begin
                    w_overrun = bus.frame_tick;
                    if (r_phase) begin
                        w_eat        = w_hit;
                        w_state_next = w_last ? S_DONE : S_CHECK;
                    end else begin
                        w_state_next = S_CHECK;
                    end
                end
                S_DONE: begin
                    w_overrun = bus.frame_tick;
                    if ((r_alive == '0) && r_ate) begin
                        w_level_clear = 1'b1;
                        w_state_next  = S_SEED;
                    end else begin
                        w_state_next = S_PLAY;
                    end
                end
                default: begin
                    w_state_next = S_SEED;
                end
            endcase
        end
    end

    // Datapath: LFSR, cycle counter, dot table, scan pipeline, score and output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr        <= 16'hBEEF;
            r_cnt         <= 16'd0;
            r_base        <= 16'd0;
            r_idx         <= '0;
            r_phase       <= 1'b0;
            r_pcx         <= 11'd0;
            r_pcy         <= 11'd0;
            r_dx          <= 11'd0;
            r_dy          <= 11'd0;
            r_x           <= '0;
            r_y           <= '0;
            r_alive       <= '0;
            r_ate         <= 1'b0;
            r_score       <= 8'd0;
            r_eat         <= 1'b0;
            r_level_clear <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_cnt         <= r_cnt + 16'd1;
            r_eat         <= w_eat;
            r_level_clear <= w_level_clear;
            r_overrun     <= w_overrun;
            r_busy        <= (w_state_next == S_SPAWN) || (w_state_next == S_CHECK);
            if (bus.soft_reset) begin
                r_lfsr <= 16'hC0DE ^ r_cnt;
            end else if (bus.frame_tick) begin
                r_lfsr <= w_lfsr_shift;
            end else begin
                r_lfsr <= r_lfsr;
            end
            if (bus.soft_reset) begin
                r_alive <= '0;
                r_idx   <= '0;
                r_phase <= 1'b0;
                r_ate   <= 1'b0;
            end else begin
                case (r_state)
                    S_SEED: begin
                        if (w_latch_base) begin
                            r_base <= w_lfsr_shift;
                            r_idx  <= '0;
                        end
                    end
                    S_SPAWN: begin
                        r_x[r_idx]     <= w_spawn_x;
                        r_y[r_idx]     <= w_spawn_y;
                        r_alive[r_idx] <= 1'b1;
                        r_idx          <= w_last ? '0 : r_idx + IDX_W'(1);
                    end
                    S_PLAY: begin
                        if (w_latch_player) begin
                            r_pcx   <= {1'b0, bus.player_x} + HALF;
                            r_pcy   <= {1'b0, bus.player_y} + HALF;
                            r_idx   <= '0;
                            r_phase <= 1'b0;
                            r_ate   <= 1'b0;
                        end
                    end
                    S_CHECK: begin
                        if (!r_phase) begin
                            r_dx    <= w_dx;
                            r_dy    <= w_dy;
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
                            if (w_eat) begin
                                r_alive[r_idx] <= 1'b0;
                                r_ate          <= 1'b1;
                                r_score        <= (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.alive_mask    = r_alive;
    assign bus.dot_x_flat    = r_x;
    assign bus.dot_y_flat    = r_y;
    assign bus.score         = r_score;
    assign bus.eat_pulse     = r_eat;
    assign bus.level_clear   = r_level_clear;
    assign bus.frame_overrun = r_overrun;
    assign bus.busy          = r_busy;
endmodule

// File: tb/tb_dot_round_ctrl.sv
// Scoreboard bench for dot_round_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them and flags any unexpected pulse.
module tb_dot_round_ctrl;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dot_round_ctrl_if #(.NUM_DOTS(N)) bus();
    dot_round_ctrl #(.NUM_DOTS(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int         cyc;
        bit         is_xy;
        logic [7:0] alive;
        logic [7:0] score;
        logic       eat;
        logic       lc;
        logic       ovr;
        logic       busy;
        int         idx;
        int         x;
        int         y;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_lfsr;
    logic [15:0] tb_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= 16'd0;
        else     tb_cnt <= tb_cnt + 16'd1;
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int fx(input logic [15:0] b, input int i);
        return ((int'(b) + i * 53) % 600) + 20;
    endfunction

    function automatic int fy(input logic [15:0] b, input int i);
        return ((int'(b) + i * 91) % 400) + 20;
    endfunction

    task automatic push(input exp_t e);
        int i = 0;
        while (i < q.size() && q[i].cyc <= e.cyc) i++;
        q.insert(i, e);
    endtask

    task automatic exp_st(input int c, input logic [7:0] alive, input logic [7:0] score,
                          input logic eat, input logic lc, input logic ovr, input logic busy);
        exp_t e;
        e.cyc = c; e.is_xy = 1'b0; e.alive = alive; e.score = score;
        e.eat = eat; e.lc = lc; e.ovr = ovr; e.busy = busy;
        e.idx = 0; e.x = 0; e.y = 0;
        push(e);
    endtask

    task automatic exp_xy(input int c, input int idx, input int x, input int y);
        exp_t e;
        e.cyc = c; e.is_xy = 1'b1; e.alive = 8'h00; e.score = 8'h00;
        e.eat = 1'b0; e.lc = 1'b0; e.ovr = 1'b0; e.busy = 1'b0;
        e.idx = idx; e.x = x; e.y = y;
        push(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle frame_tick, optionally with soft_reset; keeps the LFSR model in step.
    task automatic tick(input bit sr);
        bus.frame_tick = 1'b1;
        bus.soft_reset = sr;
        if (sr) m_lfsr = 16'hC0DE ^ tb_cnt;
        else    m_lfsr = lfsr_step(m_lfsr);
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.soft_reset = 1'b0;
    endtask

    // Monitor: compare every expectation due this cycle; pulses with nothing due are errors.
    initial begin
        exp_t e;
        bit   seen;
        int   ax, ay;
        forever begin
            @(negedge clk);
            seen = 1'b0;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_cmp++;
                if (e.cyc != cyc) begin
                    n_bad++;
                    $display("FAIL late_expect: due cycle %0d, now %0d", e.cyc, cyc);
                end else if (e.is_xy) begin
                    ax = int'(bus.dot_x_flat[10*e.idx +: 10]);
                    ay = int'(bus.dot_y_flat[10*e.idx +: 10]);
                    if (ax != e.x || ay != e.y) begin
                        n_bad++;
                        $display("FAIL dot%0d_xy @%0d: got (%0d,%0d) want (%0d,%0d)",
                                 e.idx, cyc, ax, ay, e.x, e.y);
                    end
                end else begin
                    seen = 1'b1;
                    if ({bus.alive_mask, bus.score, bus.eat_pulse, bus.level_clear,
                         bus.frame_overrun, bus.busy} !==
                        {e.alive, e.score, e.eat, e.lc, e.ovr, e.busy}) begin
                        n_bad++;
                        $display("FAIL status @%0d: got alive=%h score=%0d eat=%b lc=%b ovr=%b busy=%b want alive=%h score=%0d eat=%b lc=%b ovr=%b busy=%b",
                                 cyc, bus.alive_mask, bus.score, bus.eat_pulse, bus.level_clear,
                                 bus.frame_overrun, bus.busy, e.alive, e.score, e.eat, e.lc, e.ovr, e.busy);
                    end
                end
            end
            if (!seen && (bus.eat_pulse === 1'b1 || bus.level_clear === 1'b1 ||
                          bus.frame_overrun === 1'b1)) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse @%0d: got eat=%b lc=%b ovr=%b want none",
                         cyc, bus.eat_pulse, bus.level_clear, bus.frame_overrun);
            end
        end
    end

    int          c;
    logic [15:0] nb;
    int          x1, y1;
    logic [7:0]  mask;
    int          px[8] = '{0, 487, 540, 593, 46, 99, 152, 205};
    int          py[8] = '{0, 325, 16, 107, 198, 289, 380, 71};

    initial begin
        rst            = 1'b1;
        bus.soft_reset = 1'b0;
        bus.frame_tick = 1'b0;
        bus.player_x   = 10'd0;
        bus.player_y   = 10'd0;
        m_lfsr         = 16'hBEEF;
        idle(3);
        rst = 1'b0;
        c = cyc;
        exp_st(c + 1, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_xy(c + 1, 0, 0, 0);
        idle(3);

        // Spawn from reset seed: base 0x7DDE.
        c = cyc;
        exp_st(c + 1, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_st(c + 2, 8'h01, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_st(c + 8, 8'h7F, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_st(c + 9, 8'hFF, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_xy(c + 9, 0, 442, 242);
        exp_xy(c + 9, 1, 495, 333);
        exp_xy(c + 9, 4, 54, 206);
        exp_xy(c + 9, 7, 213, 79);
        tick(1'b0);
        idle(10);

        // Just outside the radius: d = 16^2 + 1^2 = 257.
        bus.player_x = 10'd450; bus.player_y = 10'd235;
        c = cyc;
        exp_st(c + 1,  8'hFF, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_st(c + 3,  8'hFF, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_st(c + 17, 8'hFF, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_st(c + 18, 8'hFF, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0);
        idle(20);

        // Exactly on the radius: d = 256 eats dot0 only.
        bus.player_x = 10'd450; bus.player_y = 10'd234;
        c = cyc;
        exp_st(c + 2,  8'hFF, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_st(c + 3,  8'hFE, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_st(c + 4,  8'hFE, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_st(c + 18, 8'hFE, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0);
        idle(20);

        // Dropped tick mid-scan; the player moves during the scan and must be ignored.
        bus.player_x = 10'd0; bus.player_y = 10'd0;
        c = cyc;
        exp_st(c + 6,  8'hFE, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        exp_st(c + 7,  8'hFE, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_st(c + 18, 8'hFE, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_st(c + 20, 8'hFE, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0);
        bus.player_x = 10'd487; bus.player_y = 10'd325;
        idle(4);
        tick(1'b0);
        idle(20);

        // Eat the remaining dots one frame at a time.
        for (int k = 1; k < 8; k++) begin
            bus.player_x = 10'(px[k]);
            bus.player_y = 10'(py[k]);
            mask = 8'hFF << (k + 1);
            c = cyc;
            exp_st(c + 3 + 2 * k, mask, 8'(k + 1), 1'b1, 1'b0, 1'b0, (k == 7) ? 1'b0 : 1'b1);
            if (k == 7) begin
                exp_st(c + 18, 8'h00, 8'd8, 1'b0, 1'b1, 1'b0, 1'b0);
                exp_st(c + 19, 8'h00, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);
                exp_st(c + 21, 8'h00, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                exp_st(c + 18, mask, 8'(k + 1), 1'b0, 1'b0, 1'b0, 1'b0);
            end
            tick(1'b0);
            idle(22);
        end

        // Respawn keeps the score.
        nb = lfsr_step(m_lfsr);
        c = cyc;
        exp_st(c + 9, 8'hFF, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_xy(c + 9, 0, fx(nb, 0), fy(nb, 0));
        exp_xy(c + 9, 1, fx(nb, 1), fy(nb, 1));
        x1 = fx(nb, 1);
        y1 = fy(nb, 1);
        tick(1'b0);
        idle(12);

        // Soft reset with a coincident tick lands on dot1's phase B.
        bus.player_x = 10'(x1 - 8);
        bus.player_y = 10'(y1 - 8);
        c = cyc;
        exp_st(c + 3, 8'hFF, 8'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_st(c + 5, 8'h00, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_st(c + 6, 8'h00, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_xy(c + 5, 1, x1, y1);
        tick(1'b0);
        idle(3);
        tick(1'b1);
        idle(5);

        // Next spawn must start from the loaded seed, not a shifted one.
        nb = lfsr_step(m_lfsr);
        c = cyc;
        exp_st(c + 9, 8'hFF, 8'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_xy(c + 9, 0, fx(nb, 0), fy(nb, 0));
        exp_xy(c + 9, 3, fx(nb, 3), fy(nb, 3));
        tick(1'b0);
        idle(12);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_expect: got %0d left want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
